// File: rtl/synthesizer_soc_key_input_pio.sv
// Avalon-MM input PIO: synchronizes and debounces key inputs, captures
// edges into a sticky W1C register and raises a maskable level interrupt.
module synthesizer_soc_key_input_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0,
  parameter int INPUT_RESET     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] RST_V = {WIDTH{INPUT_RESET[0]}};

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_nxt;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] new_edge;
  logic [WIDTH-1:0] clr;
  logic [CW-1:0]    cnt     [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];
  logic [31:0]      rd_mux;
  logic             wr;
  logic             unused_wdata;

  assign wr = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= RST_V;
      sync <= RST_V;
    end else begin
      s1   <= in_port;
      sync <= s1;
    end
  end

  // Any cycle where sync matches stable restarts that bit's count.
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (sync[i] != stable[i]) begin
        if (cnt[i] == CNT_MAX) begin
          stable_nxt[i] = sync[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= RST_V;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      stable <= stable_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  always_comb begin
    case (EDGE_TYPE)
      1:       new_edge = ~stable & stable_d;
      2:       new_edge = stable ^ stable_d;
      default: new_edge = stable & ~stable_d;
    endcase
  end

  assign clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = stable;
      2'd1:    rd_mux[WIDTH-1:0] = sync;
      2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
      default: rd_mux[WIDTH-1:0] = edge_capture;
    endcase
  end

  // New edges are OR-ed after the clear so a same-cycle set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_d     <= RST_V;
      edge_capture <= '0;
      irq_mask     <= '0;
      readdata     <= '0;
    end else begin
      stable_d     <= stable;
      edge_capture <= (edge_capture & ~clr) | new_edge;
      readdata     <= rd_mux;
      if (wr && address == 2'd2) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_synthesizer_soc_key_input_pio.sv
// Bench for the key input PIO: three instances (rising/falling/any edge)
// share stimulus and are compared against a windowed behavioural model.
module tb_synthesizer_soc_key_input_pio;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [31:0]  writedata;
  logic [W-1:0] in_port;
  logic [31:0]  rd   [3];
  logic         irqv [3];

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    synthesizer_soc_key_input_pio #(
      .WIDTH(W),
      .DEBOUNCE_CYCLES(D),
      .EDGE_TYPE(g),
      .INPUT_RESET(0)
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .address(address),
      .chipselect(chipselect),
      .write_n(write_n),
      .writedata(writedata),
      .in_port(in_port),
      .readdata(rd[g]),
      .irq(irqv[g])
    );
  end

  always #5 clk = ~clk;

  // Reference: a bit is accepted once the last D synchronized samples
  // all disagree with the accepted value.
  logic [W-1:0]  m_s1, m_sync, m_stable, m_prev, m_mask;
  logic [W-1:0]  m_cap [3];
  logic [31:0]   m_rd  [3];
  logic [W-1:0]  win [$];

  always @(posedge clk) begin
    logic [W-1:0] ns, ne, clr, v;
    logic all_diff;
    if (reset) begin
      m_s1 = '0; m_sync = '0; m_stable = '0; m_prev = '0; m_mask = '0;
      for (int e = 0; e < 3; e++) begin
        m_cap[e] = '0;
        m_rd[e] = '0;
      end
      win.delete();
    end else begin
      for (int e = 0; e < 3; e++) begin
        v = address == 0 ? m_stable : address == 1 ? m_sync :
            address == 2 ? m_mask : m_cap[e];
        m_rd[e] = {28'd0, v};
      end
      win.push_back(m_sync);
      if (win.size() > D) void'(win.pop_front());
      ns = m_stable;
      if (win.size() == D) begin
        for (int b = 0; b < W; b++) begin
          all_diff = 1'b1;
          foreach (win[k]) if (win[k][b] == m_stable[b]) all_diff = 1'b0;
          if (all_diff) ns[b] = ~m_stable[b];
        end
      end
      clr = (chipselect && !write_n && address == 3) ? writedata[W-1:0] : '0;
      for (int e = 0; e < 3; e++) begin
        ne = e == 0 ? (m_stable & ~m_prev) :
             e == 1 ? (~m_stable & m_prev) : (m_stable ^ m_prev);
        m_cap[e] = (m_cap[e] & ~clr) | ne;
      end
      if (chipselect && !write_n && address == 2) m_mask = writedata[W-1:0];
      m_prev = m_stable;
      m_stable = ns;
      m_sync = m_s1;
      m_s1 = in_port;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = $urandom;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    for (int e = 0; e < 3; e++) begin
      n_tests++;
      if (rd[e] !== 32'd0 || irqv[e] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset et%0d readdata=%h irq=%b want 0/0", e, rd[e], irqv[e]);
      end
    end
    reset = 1'b0;
    for (int a = 2; a < 4; a++) begin
      address = 2'(a);
      tick();
      for (int e = 0; e < 3; e++) begin
        n_tests++;
        if (rd[e] !== 32'd0) begin
          n_fail++;
          $display("FAIL reset_read a%0d et%0d got %h want 0", a, e, rd[e]);
        end
      end
    end
  endtask

  task automatic test_clean_press();
    in_port = 4'b0001;
    address = 2'd1;
    repeat (3) tick();
    n_tests++;
    if (rd[0] !== 32'h1) begin
      n_fail++;
      $display("FAIL press_raw got %h want 1", rd[0]);
    end
    address = 2'd0;
    repeat (4) begin
      tick();
      for (int e = 0; e < 3; e++) begin
        n_tests++;
        if (rd[e] !== m_rd[e]) begin
          n_fail++;
          $display("FAIL press_model et%0d got %h want %h", e, rd[e], m_rd[e]);
        end
      end
    end
    n_tests++;
    if (rd[0] !== 32'h1) begin
      n_fail++;
      $display("FAIL press_data got %h want 1", rd[0]);
    end
    address = 2'd3;
    tick();
    n_tests++;
    if (rd[0] !== 32'h1 || rd[1] !== 32'h0 || rd[2] !== 32'h1 || irqv[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL press_cap got %h/%h/%h irq=%b want 1/0/1 irq 0",
               rd[0], rd[1], rd[2], irqv[0]);
    end
  endtask

  task automatic test_glitch();
    in_port = 4'b0011;
    repeat (3) tick();
    in_port = 4'b0001;
    address = 2'd0;
    repeat (8) tick();
    n_tests++;
    if (rd[0] !== 32'h1 || rd[0] !== m_rd[0]) begin
      n_fail++;
      $display("FAIL glitch_data got %h want 1", rd[0]);
    end
    address = 2'd3;
    tick();
    n_tests++;
    if (rd[2] !== 32'h1 || rd[2] !== m_rd[2]) begin
      n_fail++;
      $display("FAIL glitch_cap got %h want 1", rd[2]);
    end
    in_port = 4'b0011;
    address = 2'd0;
    repeat (8) tick();
    n_tests++;
    if (rd[0] !== 32'h3 || rd[0] !== m_rd[0]) begin
      n_fail++;
      $display("FAIL glitch_accept got %h want 3", rd[0]);
    end
  endtask

  task automatic test_irq_clear();
    wr(2'd2, 32'h1);
    for (int e = 0; e < 3; e++) begin
      n_tests++;
      if (irqv[e] !== (|(m_cap[e] & m_mask)) || irqv[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL irq_set et%0d got %b want %b", e, irqv[e], |(m_cap[e] & m_mask));
      end
    end
    wr(2'd3, 32'h1);
    n_tests++;
    if (irqv[0] !== 1'b0 || irqv[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear got %b/%b want 0/0", irqv[0], irqv[2]);
    end
    address = 2'd3;
    tick();
    for (int e = 0; e < 3; e++) begin
      n_tests++;
      if (rd[e] !== m_rd[e] || rd[e][0] !== 1'b0) begin
        n_fail++;
        $display("FAIL irq_cap et%0d got %h want %h", e, rd[e], m_rd[e]);
      end
    end
    wr(2'd3, 32'hF);
  endtask

  task automatic test_simul();
    in_port = 4'b0111;
    repeat (6) tick();
    wr(2'd3, 32'h4);
    address = 2'd3;
    tick();
    n_tests++;
    if (rd[0][2] !== 1'b1 || rd[0] !== m_rd[0]) begin
      n_fail++;
      $display("FAIL simul got %h want %h", rd[0], m_rd[0]);
    end
  endtask

  task automatic test_release();
    wr(2'd3, 32'hF);
    in_port = 4'b1111;
    repeat (8) tick();
    wr(2'd3, 32'hF);
    in_port = 4'b0011;
    address = 2'd3;
    repeat (9) tick();
    n_tests++;
    if (rd[0] !== 32'h0 || rd[1] !== 32'hC || rd[2] !== 32'hC) begin
      n_fail++;
      $display("FAIL release got %h/%h/%h want 0/c/c", rd[0], rd[1], rd[2]);
    end
  endtask

  task automatic test_reset_mid();
    wr(2'd3, 32'hF);
    in_port = 4'b1011;
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    address = 2'd0;
    tick();
    n_tests++;
    if (rd[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_data got %h want 0", rd[0]);
    end
    address = 2'd3;
    tick();
    for (int e = 0; e < 3; e++) begin
      n_tests++;
      if (rd[e] !== 32'h0 || irqv[e] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_cap et%0d got %h irq=%b want 0", e, rd[e], irqv[e]);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold == 0) begin
        in_port = W'($urandom);
        hold = $urandom_range(1, 7);
      end else if ($urandom_range(0, 9) == 0) begin
        in_port[$urandom_range(0, W - 1)] ^= 1'b1;
      end
      hold--;
      address = 2'($urandom);
      chipselect = ($urandom_range(0, 3) == 0);
      write_n = ($urandom_range(0, 1) == 0);
      writedata = $urandom;
      tick();
      for (int e = 0; e < 3; e++) begin
        n_tests++;
        if (rd[e] !== m_rd[e] || irqv[e] !== (|(m_cap[e] & m_mask))) begin
          n_fail++;
          $display("FAIL random c%0d et%0d rd=%h irq=%b want %h/%b", c, e,
                   rd[e], irqv[e], m_rd[e], |(m_cap[e] & m_mask));
        end
      end
    end
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    address = 2'd0;
    chipselect = 1'b0;
    write_n = 1'b1;
    writedata = '0;
    in_port = '0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_irq_clear();
    test_simul();
    test_release();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
